// File: rtl/reset_sequencer_if.sv
// Lock/request inputs and staged reset outputs of the reset sequencer.
// The sequencer side owns the reset outputs and the slave side drives lock and request.
interface reset_sequencer_if #(
    parameter int NUM_STAGES = 4
);
    logic                  pll_locked;
    logic                  sw_rst_req;
    logic [NUM_STAGES-1:0] stage_rst_n;
    logic                  seq_done;
    logic [7:0]            lock_loss_cnt;
    logic [1:0]            seq_state;

    modport master (
        input  pll_locked,
        input  sw_rst_req,
        output stage_rst_n,
        output seq_done,
        output lock_loss_cnt,
        output seq_state
    );

    modport slave (
        output pll_locked,
        output sw_rst_req,
        input  stage_rst_n,
        input  seq_done,
        input  lock_loss_cnt,
        input  seq_state
    );
endinterface

// File: rtl/reset_sequencer.sv
// Releases staged resets in order once PLL lock is stable; re-asserts all on lock loss or sw request.
// Latency: lock seen 2 edges after pll_locked, all outputs registered; no backpressure.
module reset_sequencer #(
    parameter int NUM_STAGES         = 4,
    parameter int LOCK_STABLE_CYCLES = 1024,
    parameter int STAGE_DELAY        = 256,
    parameter int SW_HOLD_CYCLES     = 16,
    parameter int CNT_W              = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    reset_sequencer_if.master        seq_if
);
    localparam int IDX_W = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;
    localparam logic [CNT_W-1:0] LOCK_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] DELAY_LAST = CNT_W'(STAGE_DELAY - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(SW_HOLD_CYCLES - 1);
    localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_STAGES - 1);

    typedef enum logic [1:0] {
        ST_LOCK    = 2'd0,
        ST_RELEASE = 2'd1,
        ST_DONE    = 2'd2,
        ST_HOLD    = 2'd3
    } state_t;

    state_t                state_q, state_d;
    logic                  sync1_q, sync2_q;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [NUM_STAGES-1:0] stage_q, stage_d;
    logic                  done_q, done_d;
    logic [7:0]            llc_q, llc_d;
    logic                  lock_loss;

    // pll_locked is asynchronous to clk
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= seq_if.pll_locked;
            sync2_q <= sync1_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_LOCK;
            cnt_q   <= '0;
            idx_q   <= '0;
            stage_q <= '0;
            done_q  <= 1'b0;
            llc_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            stage_q <= stage_d;
            done_q  <= done_d;
            llc_q   <= llc_d;
        end
    end

    assign lock_loss = !sync2_q && (state_q == ST_RELEASE || state_q == ST_DONE);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        stage_d = stage_q;
        done_d  = done_q;
        llc_d   = llc_q;

        if (lock_loss) begin
            if (llc_q != 8'hFF) llc_d = llc_q + 8'd1;
            stage_d = '0;
            done_d  = 1'b0;
            cnt_d   = '0;
            idx_d   = '0;
            state_d = ST_LOCK;
        end

        // A software request overrides a simultaneous lock loss, which is still counted above
        if (seq_if.sw_rst_req) begin
            stage_d = '0;
            done_d  = 1'b0;
            cnt_d   = '0;
            idx_d   = '0;
            state_d = ST_HOLD;
        end else if (!lock_loss) begin
            unique case (state_q)
                ST_LOCK: begin
                    if (!sync2_q) begin
                        cnt_d = '0;
                    end else if (cnt_q == LOCK_LAST) begin
                        cnt_d   = '0;
                        idx_d   = '0;
                        state_d = ST_RELEASE;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                ST_RELEASE: begin
                    if (cnt_q == DELAY_LAST) begin
                        stage_d[idx_q] = 1'b1;
                        idx_d          = idx_q + IDX_W'(1);
                        cnt_d          = '0;
                        if (idx_q == IDX_LAST) begin
                            state_d = ST_DONE;
                            done_d  = 1'b1;
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                ST_DONE: begin
                end
                ST_HOLD: begin
                    if (cnt_q == HOLD_LAST) begin
                        cnt_d   = '0;
                        state_d = ST_LOCK;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                default: state_d = ST_LOCK;
            endcase
        end
    end

    assign seq_if.stage_rst_n   = stage_q;
    assign seq_if.seq_done      = done_q;
    assign seq_if.lock_loss_cnt = llc_q;
    assign seq_if.seq_state     = state_q;
endmodule

// File: tb/tb_reset_sequencer.sv
// Bench for reset_sequencer: behavioural model compared every cycle plus directed literal checks.
module tb_reset_sequencer;
    localparam int N = 4;
    localparam int L = 4;
    localparam int D = 3;
    localparam int H = 5;

    logic clk;
    logic rst_n;
    int   n_checks = 0;
    int   n_fail   = 0;

    reset_sequencer_if #(.NUM_STAGES(N)) sq_if ();

    reset_sequencer #(
        .NUM_STAGES(N), .LOCK_STABLE_CYCLES(L), .STAGE_DELAY(D),
        .SW_HOLD_CYCLES(H), .CNT_W(16)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .seq_if(sq_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: mode 0=waiting for lock, 1=releasing, 2=all released, 3=sw hold.
    // Released stages are kept as a count; the output is the thermometer of that count.
    int m_mode = 0, m_cnt = 0, m_rel = 0, m_llc = 0;
    bit m_s1 = 0, m_s2 = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_mode = 0; m_cnt = 0; m_rel = 0; m_llc = 0; m_s1 = 0; m_s2 = 0;
        end else begin
            bit ls, loss;
            ls   = m_s2;
            m_s2 = m_s1;
            m_s1 = sq_if.pll_locked;
            loss = !ls && (m_mode == 1 || m_mode == 2);
            if (loss) begin
                if (m_llc < 255) m_llc++;
                m_mode = 0; m_cnt = 0; m_rel = 0;
            end
            if (sq_if.sw_rst_req) begin
                m_mode = 3; m_cnt = 0; m_rel = 0;
            end else if (!loss) begin
                case (m_mode)
                    0: if (!ls) m_cnt = 0;
                       else if (m_cnt == L - 1) begin m_mode = 1; m_cnt = 0; end
                       else m_cnt++;
                    1: if (m_cnt == D - 1) begin
                           m_rel++; m_cnt = 0;
                           if (m_rel == N) m_mode = 2;
                       end else m_cnt++;
                    3: if (m_cnt == H - 1) begin m_mode = 0; m_cnt = 0; end
                       else m_cnt++;
                    default: ;
                endcase
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        logic [N-1:0] es;
        es = N'((1 << m_rel) - 1);
        chk("model_stage", 32'(sq_if.stage_rst_n), 32'(es));
        chk("model_done", 32'(sq_if.seq_done), 32'(m_mode == 2));
        chk("model_llc", 32'(sq_if.lock_loss_cnt), 32'(m_llc));
        chk("model_state", 32'(sq_if.seq_state), 32'(m_mode));
    end

    task automatic wait_mode(input int m, input int budget);
        int n = 0;
        while (m_mode != m && n < budget) begin
            @(negedge clk);
            n++;
        end
        n_checks++;
        if (m_mode != m) begin
            n_fail++;
            $display("FAIL wait_mode: got mode %0d expected %0d within %0d cycles", m_mode, m, budget);
        end
    endtask

    task automatic do_reset();
        @(negedge clk); #2;
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk); #1;
        rst_n = 1'b1;
    endtask

    initial begin
        int prev_llc;
        int drop_left;
        rst_n = 1'b0;
        sq_if.pll_locked = 1'b1;
        sq_if.sw_rst_req = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_stage", 32'(sq_if.stage_rst_n), 32'h0);
        chk("rst_done", 32'(sq_if.seq_done), 32'h0);
        chk("rst_llc", 32'(sq_if.lock_loss_cnt), 32'h0);
        chk("rst_state", 32'(sq_if.seq_state), 32'h0);
        #1 rst_n = 1'b1;

        // Nominal release: stages at edges 9, 12, 15, 18
        for (int e = 1; e <= 18; e++) begin
            @(negedge clk);
            if (e == 5)  chk("e5_state", 32'(sq_if.seq_state), 32'd0);
            if (e == 6)  chk("e6_state", 32'(sq_if.seq_state), 32'd1);
            if (e == 8)  chk("e8_stage", 32'(sq_if.stage_rst_n), 32'h0);
            if (e == 9)  chk("e9_stage", 32'(sq_if.stage_rst_n), 32'h1);
            if (e == 12) chk("e12_stage", 32'(sq_if.stage_rst_n), 32'h3);
            if (e == 15) chk("e15_stage", 32'(sq_if.stage_rst_n), 32'h7);
            if (e == 17) chk("e17_done", 32'(sq_if.seq_done), 32'h0);
            if (e == 18) begin
                chk("e18_stage", 32'(sq_if.stage_rst_n), 32'hF);
                chk("e18_done", 32'(sq_if.seq_done), 32'h1);
                chk("e18_state", 32'(sq_if.seq_state), 32'd2);
            end
        end

        // Lock glitch during LOCK: 3-cycle drop pushes completion to edge 24
        do_reset();
        for (int e = 1; e <= 24; e++) begin
            @(negedge clk);
            if (e == 3) #1 sq_if.pll_locked = 1'b0;
            if (e == 6) #1 sq_if.pll_locked = 1'b1;
            if (e == 23) chk("glitch_e23_done", 32'(sq_if.seq_done), 32'h0);
            if (e == 24) begin
                chk("glitch_e24_done", 32'(sq_if.seq_done), 32'h1);
                chk("glitch_llc", 32'(sq_if.lock_loss_cnt), 32'h0);
            end
        end

        // Lock loss in DONE
        @(negedge clk); #1 sq_if.pll_locked = 1'b0;
        for (int e = 1; e <= 4; e++) begin
            @(negedge clk);
            if (e == 2) chk("loss_e2_stage", 32'(sq_if.stage_rst_n), 32'hF);
            if (e == 3) begin
                chk("loss_e3_stage", 32'(sq_if.stage_rst_n), 32'h0);
                chk("loss_e3_done", 32'(sq_if.seq_done), 32'h0);
                chk("loss_llc", 32'(sq_if.lock_loss_cnt), 32'h1);
            end
        end
        #1 sq_if.pll_locked = 1'b1;
        wait_mode(2, 100);
        chk("relock_stage", 32'(sq_if.stage_rst_n), 32'hF);

        // Software request in DONE holds for H cycles
        @(negedge clk); #1 sq_if.sw_rst_req = 1'b1;
        for (int e = 1; e <= 6; e++) begin
            @(negedge clk);
            if (e == 1) begin
                #1 sq_if.sw_rst_req = 1'b0;
                chk("sw_e1_stage", 32'(sq_if.stage_rst_n), 32'h0);
                chk("sw_e1_state", 32'(sq_if.seq_state), 32'd3);
            end
            if (e == 5) chk("sw_e5_state", 32'(sq_if.seq_state), 32'd3);
            if (e == 6) chk("sw_e6_state", 32'(sq_if.seq_state), 32'd0);
        end
        wait_mode(2, 100);

        // Second request mid-HOLD restarts the hold window
        @(negedge clk); #1 sq_if.sw_rst_req = 1'b1;
        for (int e = 1; e <= 8; e++) begin
            @(negedge clk);
            if (e == 1) #1 sq_if.sw_rst_req = 1'b0;
            if (e == 2) #1 sq_if.sw_rst_req = 1'b1;
            if (e == 3) #1 sq_if.sw_rst_req = 1'b0;
            if (e == 7) chk("sw2_e7_state", 32'(sq_if.seq_state), 32'd3);
            if (e == 8) chk("sw2_e8_state", 32'(sq_if.seq_state), 32'd0);
        end

        // Simultaneous sw request and lock loss in RELEASE
        wait_mode(1, 100);
        prev_llc = m_llc;
        @(negedge clk); #1 sq_if.pll_locked = 1'b0;
        @(negedge clk);
        @(negedge clk); #1 sq_if.sw_rst_req = 1'b1;
        @(negedge clk);
        chk("simul_state", 32'(sq_if.seq_state), 32'd3);
        chk("simul_llc", 32'(sq_if.lock_loss_cnt), 32'(prev_llc + 1));
        #1 sq_if.sw_rst_req = 1'b0;
        sq_if.pll_locked = 1'b1;

        // Randomized lock drops and software requests
        drop_left = 0;
        for (int c = 0; c < 2500; c++) begin
            @(negedge clk); #1;
            sq_if.sw_rst_req = ($urandom_range(0, 59) == 0);
            if (drop_left > 0) begin
                drop_left--;
                sq_if.pll_locked = (drop_left == 0);
            end else if ($urandom_range(0, 39) == 0) begin
                drop_left = $urandom_range(1, 6);
                sq_if.pll_locked = 1'b0;
            end
        end
        sq_if.sw_rst_req = 1'b0;
        sq_if.pll_locked = 1'b1;

        // Saturation of the lock-loss counter
        for (int i = 0; i < 300; i++) begin
            wait_mode(2, 200);
            @(negedge clk); #1 sq_if.pll_locked = 1'b0;
            repeat (3) @(negedge clk);
            #1 sq_if.pll_locked = 1'b1;
        end
        wait_mode(2, 200);
        chk("sat_llc", 32'(sq_if.lock_loss_cnt), 32'd255);

        // Asynchronous reset mid-RELEASE
        @(negedge clk); #1 sq_if.sw_rst_req = 1'b1;
        @(negedge clk); #1 sq_if.sw_rst_req = 1'b0;
        wait_mode(1, 200);
        repeat (2 * D) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_stage", 32'(sq_if.stage_rst_n), 32'h0);
        chk("arst_done", 32'(sq_if.seq_done), 32'h0);
        chk("arst_llc", 32'(sq_if.lock_loss_cnt), 32'h0);
        chk("arst_state", 32'(sq_if.seq_state), 32'd0);
        repeat (2) @(negedge clk);
        #1 rst_n = 1'b1;
        repeat (4) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
